// File: rtl/diffeq_pkg.sv
// Shared encodings for the differential-equation controller and its datapath.
package diffeq_pkg;

    // Datapath state codes; the datapath decodes these same values.
    localparam logic [2:0] ST_IDLE = 3'b000;
    localparam logic [2:0] ST_READ = 3'b001;
    localparam logic [2:0] ST_C1   = 3'b010;
    localparam logic [2:0] ST_C2   = 3'b011;
    localparam logic [2:0] ST_C3   = 3'b100;
    localparam logic [2:0] ST_C4   = 3'b101;
    localparam logic [2:0] ST_DONE = 3'b110;

    // Operand index: the host delivers operands in this order.
    localparam logic [1:0] OP_X  = 2'd0;
    localparam logic [1:0] OP_DX = 2'd1;
    localparam logic [1:0] OP_A  = 2'd2;
    localparam logic [1:0] OP_U  = 2'd3;

endpackage

// File: rtl/diffeq_controller_if.sv
// Host handshake plus datapath control bundle for the diffeq controller.
interface diffeq_controller_if #(
    parameter int ITER_W = 8
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic              compute_done;
    logic              continue_while;
    logic              load_x;
    logic              load_dx;
    logic              load_a;
    logic              load_u;
    logic [2:0]        state;
    logic              busy;
    logic              done;
    logic              error;
    logic [ITER_W-1:0] iter_count;

    // Controller side: sequences the datapath and answers the host.
    modport master (
        input  start, in_valid, compute_done, continue_while,
        output in_ready, load_x, load_dx, load_a, load_u,
        output state, busy, done, error, iter_count
    );

    // Host/datapath side.
    modport slave (
        output start, in_valid, compute_done, continue_while,
        input  in_ready, load_x, load_dx, load_a, load_u,
        input  state, busy, done, error, iter_count
    );
endinterface

// File: rtl/diffeq_wait_timer.sv
// Per-compute-state cycle counter: masks early done flags and flags a stall.
module diffeq_wait_timer #(
    parameter int DONE_LAT = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic gate_open,
    output logic timeout
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count cycles since state entry, saturating so a stall never wraps.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (clear)
            wait_cnt <= '0;
        else if (wait_cnt != CNT_W'(TIMEOUT))
            wait_cnt <= wait_cnt + 1'b1;
    end

    // Done is trusted only once the datapath done pipeline has flushed.
    assign gate_open = (wait_cnt >= CNT_W'(DONE_LAT));
    // Last allowed cycle: leaving on this edge gives exactly TIMEOUT cycles.
    assign timeout   = (wait_cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/diffeq_controller.sv
// Control FSM for the differential-equation datapath: operand load,
// four-state compute loop, iteration limit and stall abort.
module diffeq_controller
    import diffeq_pkg::*;
#(
    parameter int MAX_ITER = 255,
    parameter int DONE_LAT = 2,
    parameter int TIMEOUT  = 64,
    parameter int ITER_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    diffeq_controller_if.master bus
);
    localparam logic [ITER_W-1:0] MAX_ITER_C = ITER_W'(MAX_ITER);

    logic [2:0]        state_q, state_d;
    logic [1:0]        op_idx_q;
    logic              loop_flag_q;
    logic [ITER_W-1:0] iter_q;
    logic              error_q, busy_q, done_q;
    logic              abort;
    logic              accept, done_ok, loop_take;
    logic              gate_open, timeout;
    logic [ITER_W-1:0] iter_next;

    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (v == {ITER_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    diffeq_wait_timer #(
        .DONE_LAT (DONE_LAT),
        .TIMEOUT  (TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_d != state_q),
        .gate_open (gate_open),
        .timeout   (timeout)
    );

    assign accept    = bus.in_valid && (state_q == ST_READ);
    assign done_ok   = gate_open && bus.compute_done;
    assign loop_take = loop_flag_q || bus.continue_while;
    assign iter_next = sat_inc(iter_q);

    // Next-state decode and abort detection (stall or iteration limit).
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_READ;
            ST_READ: if (accept && op_idx_q == OP_U) state_d = ST_C1;
            ST_C1, ST_C2, ST_C3: begin
                if (done_ok)
                    state_d = state_q + 3'd1;
                else if (timeout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            ST_C4: begin
                if (done_ok) begin
                    if (loop_take && iter_next < MAX_ITER_C)
                        state_d = ST_C1;
                    else begin
                        state_d = ST_DONE;
                        abort   = loop_take;
                    end
                end else if (timeout) begin
                    state_d = ST_DONE;
                    abort   = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus registered status outputs derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Run bookkeeping: operand index, loop request, iteration count, sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_idx_q    <= OP_X;
            loop_flag_q <= 1'b0;
            iter_q      <= '0;
            error_q     <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && bus.start) begin
                op_idx_q <= OP_X;
                iter_q   <= '0;
                error_q  <= 1'b0;
            end
            if (accept)
                op_idx_q <= op_idx_q + 2'd1;
            if (state_q == ST_C4 && done_ok)
                iter_q <= iter_next;
            if (abort)
                error_q <= 1'b1;
            if (state_d == ST_C4 && state_q != ST_C4)
                loop_flag_q <= 1'b0;
            else if (state_q == ST_C4 && bus.continue_while)
                loop_flag_q <= 1'b1;
        end
    end

    assign bus.in_ready   = (state_q == ST_READ);
    assign bus.load_x     = accept && (op_idx_q == OP_X);
    assign bus.load_dx    = accept && (op_idx_q == OP_DX);
    assign bus.load_a     = accept && (op_idx_q == OP_A);
    assign bus.load_u     = accept && (op_idx_q == OP_U);
    assign bus.state      = state_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_diffeq_controller.sv
// Scoreboard bench for diffeq_controller (MAX_ITER reduced to 3).
module tb_diffeq_controller;
    import diffeq_pkg::*;

    localparam int ITER_W = 8;
    localparam int EV_STROBE = 0;
    localparam int EV_EXIT   = 1;
    localparam int EV_DONE   = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    diffeq_controller_if #(.ITER_W(ITER_W)) bus ();

    diffeq_controller #(
        .MAX_ITER (3),
        .DONE_LAT (2),
        .TIMEOUT  (64),
        .ITER_W   (ITER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct { int kind; int a; int b; } ev_t;
    typedef struct { logic [18:0] val; string name; } snap_t;

    ev_t   exp_q[$];
    snap_t snap_q[$];
    int    snap_reqs = 0;
    bit    end_req = 1'b0;
    int    n_checks = 0;
    int    n_fail = 0;

    function automatic logic [18:0] pack(input logic [2:0] st, input logic rdy,
                                         input logic [3:0] ld, input logic bsy,
                                         input logic dn, input logic er,
                                         input logic [7:0] it);
        return {st, rdy, ld, bsy, dn, er, it};
    endfunction

    function automatic string kname(input int k);
        case (k)
            EV_STROBE: return "load_strobe";
            EV_EXIT:   return "state_exit(state,cycles)";
            default:   return "done_pulse(iter,error)";
        endcase
    endfunction

    // ---------------- stimulus side ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int a, input int b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_loads;
        push_ev(EV_STROBE, 1, 0);  // x
        push_ev(EV_STROBE, 2, 0);  // dx
        push_ev(EV_STROBE, 4, 0);  // a
        push_ev(EV_STROBE, 8, 0);  // u
    endtask

    task automatic push_iter;
        push_ev(EV_EXIT, int'(ST_C1), 3);
        push_ev(EV_EXIT, int'(ST_C2), 3);
        push_ev(EV_EXIT, int'(ST_C3), 3);
        push_ev(EV_EXIT, int'(ST_C4), 3);
    endtask

    task automatic snap(input string name, input logic [18:0] val);
        snap_t s;
        s.val = val; s.name = name;
        snap_q.push_back(s);
        snap_reqs++;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n;
        n = 0;
        while (bus.state != s) begin
            if (n == budget) begin
                $display("FAIL wait_state: state=%0d after %0d cycles, required %0d", bus.state, n, s);
                $fatal(1);
            end
            tick;
            n++;
        end
    endtask

    task automatic wait_leave(input logic [2:0] s);
        int n;
        n = 0;
        while (bus.state == s) begin
            if (n == 200) begin
                $display("FAIL wait_leave: still in state %0d, required exit", s);
                $fatal(1);
            end
            tick;
            n++;
        end
    endtask

    // Start from IDLE; operands x=2, dx=1, a=4, u=3 (values live on the
    // datapath bus), with 'gap' idle cycles between dx and a.
    task automatic feed_ops(input int gap, input bit check_read);
        bus.start = 1'b1; bus.in_valid = 1'b1; tick;   // IDLE: in_valid not accepted
        bus.start = 1'b0;
        if (check_read)
            snap("read_entry", pack(ST_READ, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0, 8'd0));
        tick;                                          // x taken
        tick;                                          // dx taken
        bus.in_valid = 1'b0;
        repeat (gap) tick;
        bus.in_valid = 1'b1; tick;                     // a taken
        tick;                                          // u taken
        bus.in_valid = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.in_valid = 1'b0;
        bus.compute_done = 1'b0; bus.continue_while = 1'b0;
        repeat (3) tick;
        snap("reset_state", pack(ST_IDLE, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        tick;
        reset = 1'b0;
        tick;

        // Two iterations: loop requested in first C4 only.
        bus.compute_done = 1'b1;
        push_loads; push_iter; push_iter; push_ev(EV_DONE, 2, 0);
        feed_ops(2, 1'b1);
        wait_state(ST_C4, 50);
        bus.continue_while = 1'b1; tick; bus.continue_while = 1'b0;
        wait_state(ST_C1, 50);
        wait_state(ST_C4, 50);
        wait_state(ST_IDLE, 50);

        // Stall in C2: abort after 64 cycles, error sticky in IDLE.
        push_loads;
        push_ev(EV_EXIT, int'(ST_C1), 3);
        push_ev(EV_EXIT, int'(ST_C2), 64);
        push_ev(EV_DONE, 0, 1);
        feed_ops(0, 1'b0);
        wait_state(ST_C2, 50);
        bus.compute_done = 1'b0;
        wait_state(ST_IDLE, 200);
        snap("error_sticky", pack(ST_IDLE, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'd0));
        tick;

        // Iteration limit: loop requested in every C4; start clears error.
        bus.compute_done = 1'b1;
        push_loads; push_iter; push_iter; push_iter; push_ev(EV_DONE, 3, 1);
        feed_ops(0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            wait_state(ST_C4, 50);
            bus.continue_while = 1'b1; tick; bus.continue_while = 1'b0;
            wait_leave(ST_C4);
        end
        wait_state(ST_IDLE, 50);

        // Reset in the middle of C3 of the second iteration.
        push_loads; push_iter;
        push_ev(EV_EXIT, int'(ST_C1), 3);
        push_ev(EV_EXIT, int'(ST_C2), 3);
        feed_ops(0, 1'b0);
        wait_state(ST_C4, 50);
        bus.continue_while = 1'b1; tick; bus.continue_while = 1'b0;
        wait_leave(ST_C4);
        wait_state(ST_C3, 50);
        tick;
        reset = 1'b1; bus.in_valid = 1'b1;
        snap("reset_mid_c3", pack(ST_IDLE, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 8'd0));
        tick; tick;
        bus.in_valid = 1'b0;
        reset = 1'b0;
        tick;

        // Clean single-iteration run after reset.
        push_loads; push_iter; push_ev(EV_DONE, 1, 0);
        feed_ops(1, 1'b1);
        wait_state(ST_IDLE, 50);
        repeat (3) tick;
        end_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- monitor / scoreboard side ----------------
    task automatic check_evt(input int kind, input int a, input int b);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got a=%0d b=%0d, required no event", kname(kind), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.a != a || e.b != b) begin
                n_fail++;
                $display("FAIL %s: got %s a=%0d b=%0d, required a=%0d b=%0d",
                         kname(e.kind), kname(kind), a, b, e.a, e.b);
            end
        end
    endtask

    initial begin
        logic [2:0]  prev_st;
        int          dur;
        int          snap_seen;
        logic [3:0]  ld;
        logic [18:0] got;
        snap_t       s;
        prev_st = ST_IDLE;
        dur = 0;
        snap_seen = 0;
        forever begin
            @(negedge clk);
            ld = {bus.load_u, bus.load_a, bus.load_dx, bus.load_x};
            if (ld != 4'b0000)
                check_evt(EV_STROBE, int'(ld), 0);
            if (reset) begin
                prev_st = ST_IDLE;
                dur = 0;
            end else begin
                if (bus.state == prev_st)
                    dur++;
                else begin
                    if (prev_st >= ST_C1 && prev_st <= ST_C4)
                        check_evt(EV_EXIT, int'(prev_st), dur);
                    prev_st = bus.state;
                    dur = 1;
                end
                if (bus.done)
                    check_evt(EV_DONE, int'(bus.iter_count), int'(bus.error));
            end
            if (snap_reqs != snap_seen) begin
                snap_seen++;
                s = snap_q.pop_front();
                got = pack(bus.state, bus.in_ready, ld, bus.busy, bus.done,
                           bus.error, bus.iter_count);
                n_checks++;
                if (got !== s.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h, required %h", s.name, got, s.val);
                end
            end
            if (end_req) begin
                n_checks++;
                if (exp_q.size() != 0 || snap_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL queue_drained: got %0d events and %0d snapshots left, required 0",
                             exp_q.size(), snap_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

endmodule
